// File: rtl/rf_wb_arb.sv
// Write-back arbiter for the shared register-file write port, plus a busy
// scoreboard and a bypass/stall query path for decode.
module rf_wb_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REG    = 32
) (
  input  logic                    clk,
  input  logic                    rst_p,
  input  logic [2:0]              req_valid,
  output logic [2:0]              req_ready,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [3*DATA_WIDTH-1:0] req_data,
  input  logic                    iss_valid,
  input  logic [ADDR_WIDTH-1:0]   iss_addr,
  input  logic                    clr,
  input  logic [ADDR_WIDTH-1:0]   q_addr1,
  input  logic [ADDR_WIDTH-1:0]   q_addr2,
  output logic                    q_busy1,
  output logic                    q_busy2,
  output logic                    q_fwd1,
  output logic                    q_fwd2,
  output logic [DATA_WIDTH-1:0]   q_fdata1,
  output logic [DATA_WIDTH-1:0]   q_fdata2,
  output logic                    rf_wen,
  output logic [ADDR_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  logic [1:0]            rr_ptr_r;
  logic [NUM_REG-1:0]    busy_r;
  logic [NUM_REG-1:0]    busy_nxt_s;
  logic [2:0]            pick_s;
  logic                  grant_vld_s;
  logic [1:0]            grant_idx_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  hit1_s;
  logic                  hit2_s;

  // Returns {found, index} of the first valid source in the order a, b, c.
  function automatic logic [2:0] pick(input logic [2:0] v, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] c);
    logic [2:0] r;
    if (v[a]) begin
      r = {1'b1, a};
    end else if (v[b]) begin
      r = {1'b1, b};
    end else if (v[c]) begin
      r = {1'b1, c};
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Round-robin search starting at rr_ptr_r.
  always_comb begin
    pick_s = 3'b000;
    case (rr_ptr_r)
      2'd1:    pick_s = pick(req_valid, 2'd1, 2'd2, 2'd0);
      2'd2:    pick_s = pick(req_valid, 2'd2, 2'd0, 2'd1);
      default: pick_s = pick(req_valid, 2'd0, 2'd1, 2'd2);
    endcase
  end

  assign grant_vld_s = pick_s[2];
  assign grant_idx_s = pick_s[1:0];
  assign req_ready   = grant_vld_s ? (3'b001 << grant_idx_s) : 3'b000;

  // Mux the granted source's address and data.
  always_comb begin
    sel_addr_s = req_addr[0 +: ADDR_WIDTH];
    sel_data_s = req_data[0 +: DATA_WIDTH];
    case (grant_idx_s)
      2'd1: begin
        sel_addr_s = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_s = req_data[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_addr_s = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_s = req_data[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        sel_addr_s = req_addr[0 +: ADDR_WIDTH];
        sel_data_s = req_data[0 +: DATA_WIDTH];
      end
    endcase
  end

  // Pointer moves past the winner only on an actual handshake.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      rr_ptr_r <= 2'd0;
    end else if (grant_vld_s) begin
      rr_ptr_r <= (grant_idx_s == 2'd2) ? 2'd0 : grant_idx_s + 2'd1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Registered write port; writes to r0 are consumed but never enabled.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      rf_wen   <= 1'b0;
      rf_waddr <= ADDR_ZERO;
      rf_wdata <= {DATA_WIDTH{1'b0}};
    end else if (grant_vld_s && (sel_addr_s != ADDR_ZERO)) begin
      rf_wen   <= 1'b1;
      rf_waddr <= sel_addr_s;
      rf_wdata <= sel_data_s;
    end else begin
      rf_wen   <= 1'b0;
      rf_waddr <= rf_waddr;
      rf_wdata <= rf_wdata;
    end
  end

  // Scoreboard next state: a new issue supersedes a retiring write to the same register.
  always_comb begin
    busy_nxt_s = busy_r;
    if (clr) begin
      busy_nxt_s = {NUM_REG{1'b0}};
    end else begin
      if (rf_wen) begin
        busy_nxt_s[rf_waddr] = 1'b0;
      end else begin
        busy_nxt_s = busy_r;
      end
      if (iss_valid && (iss_addr != ADDR_ZERO)) begin
        busy_nxt_s[iss_addr] = 1'b1;
      end else begin
        busy_nxt_s[0] = 1'b0;
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      busy_r <= {NUM_REG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign hit1_s   = rf_wen && (rf_waddr == q_addr1) && (q_addr1 != ADDR_ZERO);
  assign hit2_s   = rf_wen && (rf_waddr == q_addr2) && (q_addr2 != ADDR_ZERO);
  assign q_fwd1   = hit1_s;
  assign q_fwd2   = hit2_s;
  assign q_fdata1 = hit1_s ? rf_wdata : {DATA_WIDTH{1'b0}};
  assign q_fdata2 = hit2_s ? rf_wdata : {DATA_WIDTH{1'b0}};
  assign q_busy1  = busy_r[q_addr1] & ~hit1_s;
  assign q_busy2  = busy_r[q_addr2] & ~hit2_s;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed and randomized checks of rf_wb_arb against a cycle-level reference model.
module tb_rf_wb_arb;

  logic        clk;
  logic        rst_p;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        clr;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_busy1, q_busy2, q_fwd1, q_fwd2;
  logic [31:0] q_fdata1, q_fdata2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_rr;
  bit          m_wen;
  bit [4:0]    m_waddr;
  bit [31:0]   m_wdata;
  bit [31:0]   m_busy;

  rf_wb_arb dut (
    .clk(clk), .rst_p(rst_p), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .clr(clr), .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_busy1(q_busy1), .q_busy2(q_busy2), .q_fwd1(q_fwd1), .q_fwd2(q_fwd2),
    .q_fdata1(q_fdata1), .q_fdata2(q_fdata2), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_rr + k) % 3;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
  endtask

  // advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    int g;
    bit old_wen;
    bit [4:0] old_waddr;
    bit [4:0] a;
    if (rst_p) begin
      model_reset();
      return;
    end
    g = exp_grant();
    old_wen = m_wen;
    old_waddr = m_waddr;
    m_wen = 0;
    if (g >= 0) begin
      a = req_addr[g*5 +: 5];
      m_rr = (g + 1) % 3;
      if (a != 0) begin
        m_wen = 1; m_waddr = a; m_wdata = req_data[g*32 +: 32];
      end
    end
    if (clr) begin
      m_busy = 0;
    end else begin
      if (old_wen) m_busy[old_waddr] = 0;
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  endtask

  task automatic check_all();
    int g;
    bit h1, h2;
    g = exp_grant();
    h1 = m_wen && (m_waddr == q_addr1) && (q_addr1 != 0);
    h2 = m_wen && (m_waddr == q_addr2) && (q_addr2 != 0);
    chk("req_ready", {29'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
    chk("rf_wen", {31'd0, rf_wen}, {31'd0, m_wen});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("q_fwd1", {31'd0, q_fwd1}, {31'd0, h1});
    chk("q_fwd2", {31'd0, q_fwd2}, {31'd0, h2});
    chk("q_fdata1", q_fdata1, h1 ? m_wdata : 32'd0);
    chk("q_fdata2", q_fdata2, h2 ? m_wdata : 32'd0);
    chk("q_busy1", {31'd0, q_busy1}, {31'd0, m_busy[q_addr1] & ~h1});
    chk("q_busy2", {31'd0, q_busy2}, {31'd0, m_busy[q_addr2] & ~h2});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst_p = 1'b1; req_valid = 3'b000; req_addr = '0; req_data = '0;
    iss_valid = 1'b0; iss_addr = 5'd0; clr = 1'b0; q_addr1 = 5'd1; q_addr2 = 5'd2;
    model_reset();
    tick(); tick();
    rst_p = 1'b0;
    #1;
    // reset / idle
    chk("idle_ready", {29'd0, req_ready}, 32'd0);
    chk("idle_wen", {31'd0, rf_wen}, 32'd0);
    chk("idle_busy1", {31'd0, q_busy1}, 32'd0);
    chk("idle_busy2", {31'd0, q_busy2}, 32'd0);
    check_all();
    tick();

    // all three sources valid: strict rotation
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_order", {29'd0, req_ready}, 32'd1 << (i % 3));
      check_all();
      tick();
      chk("rr_waddr", {27'd0, rf_waddr}, i % 3 + 1);
      chk("rr_wen", {31'd0, rf_wen}, 32'd1);
    end
    req_valid = 3'b000;
    #1 check_all();
    tick();

    // issue r5, then src1 writes r5 = 0xDEAD
    iss_valid = 1'b1; iss_addr = 5'd5;
    #1 check_all();
    tick();
    iss_valid = 1'b0; q_addr1 = 5'd5;
    req_valid = 3'b010; req_addr = {5'd0, 5'd5, 5'd0}; req_data = {32'd0, 32'hDEAD, 32'd0};
    #1;
    chk("r5_busy_pre", {31'd0, q_busy1}, 32'd1);
    chk("r5_ready", {29'd0, req_ready}, 32'd2);
    check_all();
    tick();
    req_valid = 3'b000;
    #1;
    chk("r5_busy_fwd", {31'd0, q_busy1}, 32'd0);
    chk("r5_fwd", {31'd0, q_fwd1}, 32'd1);
    chk("r5_fdata", q_fdata1, 32'hDEAD);
    check_all();
    tick();
    chk("r5_busy_post", {31'd0, q_busy1}, 32'd0);
    chk("r5_fwd_post", {31'd0, q_fwd1}, 32'd0);
    check_all();

    // retire r7 on the same edge r7 is re-issued: set wins; clr later clears it
    req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd7}; req_data = {32'd0, 32'd0, 32'h77};
    #1 check_all();
    tick();
    req_valid = 3'b000; iss_valid = 1'b1; iss_addr = 5'd7;
    #1 check_all();
    tick();
    iss_valid = 1'b0; q_addr2 = 5'd7;
    #1;
    chk("r7_set_wins", {31'd0, q_busy2}, 32'd1);
    check_all();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("r7_clr", {31'd0, q_busy2}, 32'd0);
    check_all();

    // src2 writes r0: consumed, no write, pointer wraps to 0; issue to r0 ignored
    req_valid = 3'b100; req_addr = {5'd0, 5'd0, 5'd0}; req_data = {32'hFFFF_FFFF, 64'd0};
    iss_valid = 1'b1; iss_addr = 5'd0;
    #1;
    chk("r0_ready", {29'd0, req_ready}, 32'd4);
    check_all();
    tick();
    req_valid = 3'b000; iss_valid = 1'b0; q_addr1 = 5'd0;
    #1;
    chk("r0_wen", {31'd0, rf_wen}, 32'd0);
    chk("r0_busy", {31'd0, q_busy1}, 32'd0);
    chk("r0_fwd", {31'd0, q_fwd1}, 32'd0);
    req_valid = 3'b111;
    #1;
    chk("r0_rr_wrap", {29'd0, req_ready}, 32'd1);
    req_valid = 3'b000;
    #1 check_all();

    // asynchronous reset mid-stream
    iss_valid = 1'b1; iss_addr = 5'd3; q_addr1 = 5'd3;
    req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd9}; req_data = {64'd0, 32'h99};
    #1 check_all();
    tick();
    iss_valid = 1'b0; req_valid = 3'b000;
    #1;
    chk("rst_pre_busy", {31'd0, q_busy1}, 32'd1);
    chk("rst_pre_wen", {31'd0, rf_wen}, 32'd1);
    rst_p = 1'b1;
    #1;
    chk("rst_async_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_async_busy", {31'd0, q_busy1}, 32'd0);
    req_valid = 3'b111;
    #1;
    chk("rst_async_rr", {29'd0, req_ready}, 32'd1);
    req_valid = 3'b000;
    model_reset();
    #1 rst_p = 1'b0;
    #1 check_all();
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int s = 0; s < 3; s++) begin
        req_addr[s*5 +: 5]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        req_data[s*32 +: 32] = $urandom;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = 5'($urandom_range(0, 31));
      clr       = ($urandom_range(0, 15) == 0);
      q_addr1   = 5'($urandom_range(0, 31));
      q_addr2   = ($urandom_range(0, 1) == 1) ? rf_waddr : 5'($urandom_range(0, 31));
      #1 check_all();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
